// File: rtl/water_inlet_arbiter_if.sv
// Bundle of the fill request/grant signals between the washing machine
// controllers and the water inlet arbiter.
interface water_inlet_arbiter_if #(
  parameter int N_MACHINES = 4,
  parameter int ID_W       = 2
);
  logic [N_MACHINES-1:0] fill_req;
  logic [N_MACHINES-1:0] fill_done;
  logic [N_MACHINES-1:0] grant;
  logic [ID_W-1:0]       grant_id;
  logic                  main_valve;
  logic                  busy;
  logic                  timeout_err;
  logic [ID_W-1:0]       timeout_id;
  logic [15:0]           grant_count;

  modport master (
    output fill_req, fill_done,
    input  grant, grant_id, main_valve, busy, timeout_err, timeout_id, grant_count
  );

  modport slave (
    input  fill_req, fill_done,
    output grant, grant_id, main_valve, busy, timeout_err, timeout_id, grant_count
  );
endinterface

// File: rtl/water_inlet_arbiter.sv
// Round-robin arbiter sharing the mains water inlet between N machine controllers,
// with fill timeout, valve-settle cooldown and emergency stop. WATER_ARB_STATS_EN adds a grant counter.
module water_inlet_arbiter #(
  parameter int N_MACHINES      = 4,
  parameter int ID_W            = 2,
  parameter int MAX_FILL_CYCLES = 16,
  parameter int COOLDOWN_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stop,
  water_inlet_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_COOLDOWN} state_t;

  state_t                r_state, w_state_next;
  logic [7:0]            r_timer, w_timer_next;
  logic [ID_W-1:0]       r_rr_ptr, w_rr_ptr_next;
  logic [N_MACHINES-1:0] r_grant, w_grant_next;
  logic [ID_W-1:0]       r_grant_id, w_grant_id_next;
  logic                  r_main_valve, w_main_valve_next;
  logic                  r_busy, w_busy_next;
  logic                  r_timeout_err, w_timeout_err_next;
  logic [ID_W-1:0]       r_timeout_id, w_timeout_id_next;

  logic [2*N_MACHINES-1:0] w_req2;
  logic [N_MACHINES-1:0]   w_rot;
  logic                    w_pick_found;
  logic [ID_W-1:0]         w_pick_id;
  logic                    w_done_g, w_req_g, w_timer_max, w_release, w_timeout;
  logic                    w_cool_end;
  logic [ID_W-1:0]         w_rr_after;

  // Rotate requests so bit 0 is the round-robin pointer; lowest set bit wins.
  assign w_req2 = {bus.fill_req, bus.fill_req};
  assign w_rot  = N_MACHINES'(w_req2 >> r_rr_ptr);

  always_comb begin
    w_pick_found = 1'b0;
    w_pick_id    = '0;
    for (int k = N_MACHINES - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_pick_found = 1'b1;
        w_pick_id    = (int'(r_rr_ptr) + k >= N_MACHINES) ?
                       ID_W'(int'(r_rr_ptr) + k - N_MACHINES) : ID_W'(int'(r_rr_ptr) + k);
      end
    end
  end

  assign w_done_g    = bus.fill_done[r_grant_id];
  assign w_req_g     = bus.fill_req[r_grant_id];
  assign w_timer_max = (r_timer == 8'(MAX_FILL_CYCLES - 1));
  assign w_release   = w_done_g || !w_req_g || w_timer_max;
  // A done pulse coinciding with the last timer cycle counts as a normal release.
  assign w_timeout   = w_timer_max && !w_done_g && w_req_g;
  assign w_cool_end  = (r_timer == 8'(COOLDOWN_CYCLES - 1));
  assign w_rr_after  = (r_grant_id == ID_W'(N_MACHINES - 1)) ? '0 : r_grant_id + ID_W'(1);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (stop) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:     if (w_pick_found) w_state_next = S_GRANT;
        S_GRANT:    if (w_release) w_state_next = (COOLDOWN_CYCLES > 0) ? S_COOLDOWN : S_IDLE;
        S_COOLDOWN: if (w_cool_end) w_state_next = S_IDLE;
        default:    w_state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_timer_next       = r_timer;
    w_rr_ptr_next      = r_rr_ptr;
    w_grant_next       = r_grant;
    w_grant_id_next    = r_grant_id;
    w_main_valve_next  = r_main_valve;
    w_timeout_err_next = 1'b0;
    w_timeout_id_next  = r_timeout_id;
    if (stop) begin
      w_timer_next      = '0;
      w_grant_next      = '0;
      w_grant_id_next   = '0;
      w_main_valve_next = 1'b0;
      if (r_state == S_GRANT) w_rr_ptr_next = w_rr_after;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pick_found) begin
            w_grant_next      = N_MACHINES'(1) << w_pick_id;
            w_grant_id_next   = w_pick_id;
            w_main_valve_next = 1'b1;
            w_timer_next      = '0;
          end
        end
        S_GRANT: begin
          if (w_release) begin
            w_grant_next       = '0;
            w_grant_id_next    = '0;
            w_main_valve_next  = 1'b0;
            w_timer_next       = '0;
            w_rr_ptr_next      = w_rr_after;
            w_timeout_err_next = w_timeout;
            if (w_timeout) w_timeout_id_next = r_grant_id;
          end else begin
            w_timer_next = r_timer + 8'd1;
          end
        end
        S_COOLDOWN: w_timer_next = w_cool_end ? 8'd0 : r_timer + 8'd1;
        default:    w_timer_next = '0;
      endcase
    end
    w_busy_next = (w_state_next != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_timer       <= '0;
      r_rr_ptr      <= '0;
      r_grant       <= '0;
      r_grant_id    <= '0;
      r_main_valve  <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_timeout_id  <= '0;
    end else begin
      r_timer       <= w_timer_next;
      r_rr_ptr      <= w_rr_ptr_next;
      r_grant       <= w_grant_next;
      r_grant_id    <= w_grant_id_next;
      r_main_valve  <= w_main_valve_next;
      r_busy        <= w_busy_next;
      r_timeout_err <= w_timeout_err_next;
      r_timeout_id  <= w_timeout_id_next;
    end
  end

  assign bus.grant       = r_grant;
  assign bus.grant_id    = r_grant_id;
  assign bus.main_valve  = r_main_valve;
  assign bus.busy        = r_busy;
  assign bus.timeout_err = r_timeout_err;
  assign bus.timeout_id  = r_timeout_id;

`ifdef WATER_ARB_STATS_EN
  logic [15:0] r_grant_count;

  always_ff @(posedge clk) begin
    if (reset)
      r_grant_count <= '0;
    else if (r_state == S_IDLE && w_state_next == S_GRANT && r_grant_count != 16'hFFFF)
      r_grant_count <= r_grant_count + 16'd1;
  end

  assign bus.grant_count = r_grant_count;
`else
  assign bus.grant_count = '0;
`endif

endmodule
